acc_load_sequencer: RTL and testbench
=====================================

# acc_load_sequencer

Sequencer that owns the accumulator input multiplexer select and the accumulator write enable. It accepts load requests from the control unit, names one of seven accumulator sources, and drives a one-cycle accumulator write. Sources that need a peripheral handshake (UART receive data, SPI receive buffer) get a read request/acknowledge exchange with a timeout. It sits between the control unit and the accumulator mux/accumulator register; the control unit stalls on `busy`.

## Interface
- `SEL_W`, default 3: width of the mux select; matches the accumulator mux select length.
- `TIMEOUT`, default 16: maximum cycles spent waiting for a peripheral acknowledge (≥2).
- `IDLE_SEL`, default 3'd7: select value driven while idle, an unmapped code so the mux output floats.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ldReq`  in  1  single-cycle load request from the control unit; honoured only when `busy`=0.
- `ldSrc`  in  SEL_W  source code, sampled with `ldReq`:
  - 0 immData, 1 aluOut, 2 tcLoad, 3 tcAcc, 4 uart, 5 spiStat, 6 spiBuf.
  - 7 is invalid.
- `uartAck`  in  1  UART has placed valid data on its data output.
- `spiAck`  in  1  SPI has placed valid data on its buffer output.
- `errClr`  in  1  clears both sticky error flags.
- `accMuxSel`  out  SEL_W  registered select to the accumulator mux.
- `accWrEn`  out  1  registered one-cycle accumulator write enable.
- `uartRdReq`  out  1  registered read request to the UART.
- `spiRdReq`  out  1  registered read request to the SPI.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a load completes, whether it wrote or aborted.
- `errTimeout`  out  1  sticky: a handshake load timed out.
- `errSrc`  out  1  sticky: a load request arrived with an invalid source.

## Operation
- State machine with three states: IDLE, WAIT_ACK, WRITE.
- Direct sources are codes 0–3 and 5. Handshake sources are 4 (UART) and 6 (SPI buffer).
- **IDLE**
  - `ldReq`=1 with a direct source: latch `ldSrc` into `srcReg`, go to WRITE.
  - `ldReq`=1 with a handshake source: latch `srcReg`, clear the wait counter, assert the matching read request, go to WAIT_ACK.
  - `ldReq`=1 with `ldSrc`=7: set `errSrc`, pulse `done`, stay in IDLE, no write.
- **WAIT_ACK**
  - Hold `accMuxSel`=`srcReg` and keep the matching read request high. Only the ack that matches `srcReg` counts; the other ack is ignored.
  - Matching ack sampled high: drop the read request, go to WRITE.
  - Otherwise, when the counter reaches TIMEOUT-1: drop the read request, set `errTimeout`, pulse `done`, go to IDLE with no write.
  - Otherwise: increment the counter.
- **WRITE**
  - `accMuxSel`=`srcReg`, `accWrEn`=1, `done`=1 for exactly one cycle, then go to IDLE.
- **Output values**
  - In IDLE, `accMuxSel`=IDLE_SEL.
  - `accWrEn` is high only in WRITE.
  - At most one read request is high at any time.
- **Simultaneous events**
  - `ldReq` while `busy`=1 is ignored; nothing is queued.
  - An ack sampled in the same cycle as the terminal count wins: the load writes and no error is set.
  - `errClr` in the same cycle as an error-setting event: the set wins.
- **Reset (`reset`=0 at a clock edge)**
  - State goes to IDLE; `accMuxSel`=IDLE_SEL.
  - `accWrEn`, `uartRdReq`, `spiRdReq`, `busy`, `done`, `errTimeout`, `errSrc` all go to 0; the counter and `srcReg` clear.
  - Reset in the middle of a load aborts it with no write and no `done`.

## Timing
- Direct load: `ldReq` sampled at edge N → `accWrEn`=`done`=1 during cycle N+1 → `busy` low from N+2.
- Handshake load:
  - `ldReq` at edge N → read request high from N+1.
  - Ack sampled at edge M → read request low and `accWrEn` high during cycle M+1.
- Timeout: with no ack, the read request is high for exactly TIMEOUT cycles. `done` and `errTimeout` assert in the cycle after the last wait cycle.
- Back-to-back direct loads: one load accepted every 2 cycles, because `busy` is high during WRITE.
- `accMuxSel` is stable for the whole of the cycle in which `accWrEn` is high.

## Test plan
- Reset, then `ldReq` with `ldSrc`=1 → one cycle later `accMuxSel`=1, `accWrEn`=1, `done`=1; the next cycle `accMuxSel`=7 and `busy`=0.
- `ldReq` with `ldSrc`=4, `uartAck` raised 3 cycles later → `uartRdReq` high for 3 cycles, then `accWrEn`=1 with `accMuxSel`=4; `spiRdReq` stays 0 throughout.
- `ldReq` with `ldSrc`=6, `spiAck` never raised (TIMEOUT=16) → `spiRdReq` high for 16 cycles, then `done`=1, `errTimeout`=1, no `accWrEn`; `errClr` → `errTimeout`=0.
- `ldReq` with `ldSrc`=7 → `errSrc`=1 and `done` pulse the next cycle, `busy` stays 0; a second `ldReq` with `ldSrc`=2 while WRITE is active → ignored.
- Ack and terminal count in the same cycle → the write occurs and `errTimeout` stays 0. `errClr` together with an invalid source → `errSrc`=1.
- `reset`=0 during WAIT_ACK → the next cycle all outputs are at reset values, and no `accWrEn` or `done` appears afterwards.

Source files
------------

// File: rtl/acc_load_sequencer.sv
// Accumulator load sequencer: owns the accumulator mux select and write enable,
// and runs a timed read request/acknowledge exchange for UART and SPI-buffer sources.
module acc_load_sequencer #(
    parameter int unsigned      SEL_W    = 3,
    parameter int unsigned      TIMEOUT  = 16,
    parameter logic [SEL_W-1:0] IDLE_SEL = SEL_W'(7)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ldReq,
    input  logic [SEL_W-1:0] ldSrc,
    input  logic             uartAck,
    input  logic             spiAck,
    input  logic             errClr,
    output logic [SEL_W-1:0] accMuxSel,
    output logic             accWrEn,
    output logic             uartRdReq,
    output logic             spiRdReq,
    output logic             busy,
    output logic             done,
    output logic             errTimeout,
    output logic             errSrc
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [SEL_W-1:0] SRC_UART      = SEL_W'(4);
    localparam logic [SEL_W-1:0] SRC_SPI_BUF   = SEL_W'(6);
    localparam logic [SEL_W-1:0] SRC_MAX_VALID = SEL_W'(6);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WRITE
    } state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] src_reg, src_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [SEL_W-1:0] mux_sel_nx;
    logic             wr_en_nx;
    logic             uart_req_nx;
    logic             spi_req_nx;
    logic             done_nx;
    logic             abort_evt;
    logic             timeout_evt;
    logic             bad_src_evt;
    logic             err_timeout_nx;
    logic             err_src_nx;
    logic             ack_match;
    logic             req_handshake;

    // Only the acknowledge belonging to the latched source may complete a wait.
    assign ack_match = ((src_reg == SRC_UART)    && uartAck) ||
                       ((src_reg == SRC_SPI_BUF) && spiAck);

    assign req_handshake = (ldSrc == SRC_UART) || (ldSrc == SRC_SPI_BUF);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // one unassigned and infer a latch.
        state_nx    = state;
        src_nx      = src_reg;
        cnt_nx      = cnt;
        abort_evt   = 1'b0;
        timeout_evt = 1'b0;
        bad_src_evt = 1'b0;

        case (state)
            IDLE: begin
                if (ldReq) begin
                    if (ldSrc > SRC_MAX_VALID) begin
                        bad_src_evt = 1'b1;
                        abort_evt   = 1'b1;
                    end else if (req_handshake) begin
                        src_nx   = ldSrc;
                        cnt_nx   = '0;
                        state_nx = WAIT_ACK;
                    end else begin
                        src_nx   = ldSrc;
                        state_nx = WRITE;
                    end
                end
            end
            WAIT_ACK: begin
                // An ack on the terminal-count cycle still wins over the timeout.
                if (ack_match) begin
                    state_nx = WRITE;
                end else if (cnt == CNT_LAST) begin
                    timeout_evt = 1'b1;
                    abort_evt   = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        wr_en_nx    = (state_nx == WRITE);
        done_nx     = (state_nx == WRITE) || abort_evt;
        uart_req_nx = (state_nx == WAIT_ACK) && (src_nx == SRC_UART);
        spi_req_nx  = (state_nx == WAIT_ACK) && (src_nx == SRC_SPI_BUF);
        mux_sel_nx  = (state_nx == IDLE) ? IDLE_SEL : src_nx;

        err_timeout_nx = timeout_evt || (errTimeout && !errClr);
        err_src_nx     = bad_src_evt || (errSrc && !errClr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            src_reg    <= '0;
            cnt        <= '0;
            accMuxSel  <= IDLE_SEL;
            accWrEn    <= 1'b0;
            uartRdReq  <= 1'b0;
            spiRdReq   <= 1'b0;
            done       <= 1'b0;
            errTimeout <= 1'b0;
            errSrc     <= 1'b0;
        end else begin
            state      <= state_nx;
            src_reg    <= src_nx;
            cnt        <= cnt_nx;
            accMuxSel  <= mux_sel_nx;
            accWrEn    <= wr_en_nx;
            uartRdReq  <= uart_req_nx;
            spiRdReq   <= spi_req_nx;
            done       <= done_nx;
            errTimeout <= err_timeout_nx;
            errSrc     <= err_src_nx;
        end
    end

    assign busy = (state != IDLE);

    a_one_req : assert property (@(posedge clk) disable iff (!reset)
        !(uartRdReq && spiRdReq));
    a_wr_in_write : assert property (@(posedge clk) disable iff (!reset)
        accWrEn == (state == WRITE));
    a_idle_sel : assert property (@(posedge clk) disable iff (!reset)
        (state == IDLE) |-> (accMuxSel == IDLE_SEL));

endmodule

// File: tb/tb_acc_load_sequencer.sv
// Directed bench for acc_load_sequencer: a table of single-cycle vectors plus
// hand-written sequences for timeout, ack-at-terminal-count and mid-load reset.
module tb_acc_load_sequencer;

    logic       clk;
    logic       reset;
    logic       ldReq;
    logic [2:0] ldSrc;
    logic       uartAck;
    logic       spiAck;
    logic       errClr;
    logic [2:0] accMuxSel;
    logic       accWrEn;
    logic       uartRdReq;
    logic       spiRdReq;
    logic       busy;
    logic       done;
    logic       errTimeout;
    logic       errSrc;

    int n_pass  = 0;
    int n_total = 0;

    acc_load_sequencer #(
        .SEL_W   (3),
        .TIMEOUT (16),
        .IDLE_SEL(3'd7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ldReq     (ldReq),
        .ldSrc     (ldSrc),
        .uartAck   (uartAck),
        .spiAck    (spiAck),
        .errClr    (errClr),
        .accMuxSel (accMuxSel),
        .accWrEn   (accWrEn),
        .uartRdReq (uartRdReq),
        .spiRdReq  (spiRdReq),
        .busy      (busy),
        .done      (done),
        .errTimeout(errTimeout),
        .errSrc    (errSrc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       req;
        logic [2:0] src;
        logic       uack;
        logic       sack;
        logic       clr;
        logic [9:0] exp;
    } vec_t;

    // Packed view: {sel[2:0], wr, ureq, sreq, busy, done, etmo, esrc}
    function automatic logic [9:0] pk(input logic [2:0] sel, input logic wr, input logic ur,
                                      input logic sr, input logic bz, input logic dn,
                                      input logic et, input logic es);
        return {sel, wr, ur, sr, bz, dn, et, es};
    endfunction

    function automatic logic [9:0] outs();
        return {accMuxSel, accWrEn, uartRdReq, spiRdReq, busy, done, errTimeout, errSrc};
    endfunction

    function automatic vec_t mk(input string n, input logic req, input logic [2:0] src,
                                input logic ua, input logic sa, input logic clr,
                                input logic [9:0] exp);
        vec_t v;
        v.name = n;
        v.req  = req;
        v.src  = src;
        v.uack = ua;
        v.sack = sa;
        v.clr  = clr;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ldReq   = 1'b0;
        ldSrc   = 3'd0;
        uartAck = 1'b0;
        spiAck  = 1'b0;
        errClr  = 1'b0;
    endtask

    vec_t vecs[$];
    int   n_req;
    logic saw_bad;

    initial begin
        reset = 1'b0;
        idle_inputs();

        step();
        check("reset_state", 32'(outs()), 32'(pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        step();
        reset = 1'b1;

        //                name            req src ua sa clr   sel  wr ur sr bz dn et es
        vecs.push_back(mk("idle",          0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("direct1_wr",    1, 1, 0, 0, 0, pk(3'd1, 1, 0, 0, 1, 1, 0, 0)));
        vecs.push_back(mk("direct1_back",  0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("uart_req",      1, 4, 0, 0, 0, pk(3'd4, 0, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("uart_wait1",    0, 0, 0, 0, 0, pk(3'd4, 0, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("uart_spiack",   0, 0, 0, 1, 0, pk(3'd4, 0, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("uart_ack_wr",   0, 0, 1, 0, 0, pk(3'd4, 1, 0, 0, 1, 1, 0, 0)));
        vecs.push_back(mk("uart_back",     0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("bad_src_clr",   1, 7, 0, 0, 1, pk(3'd7, 0, 0, 0, 0, 1, 0, 1)));
        vecs.push_back(mk("direct2_wr",    1, 2, 0, 0, 0, pk(3'd2, 1, 0, 0, 1, 1, 0, 1)));
        vecs.push_back(mk("req_in_write",  1, 3, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk("no_queue",      0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk("err_clr",       0, 0, 0, 0, 1, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("direct0_wr",    1, 0, 0, 0, 0, pk(3'd0, 1, 0, 0, 1, 1, 0, 0)));
        vecs.push_back(mk("direct0_back",  0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("direct5_wr",    1, 5, 0, 0, 0, pk(3'd5, 1, 0, 0, 1, 1, 0, 0)));
        vecs.push_back(mk("direct5_back",  0, 0, 0, 0, 0, pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));

        foreach (vecs[i]) begin
            ldReq   = vecs[i].req;
            ldSrc   = vecs[i].src;
            uartAck = vecs[i].uack;
            spiAck  = vecs[i].sack;
            errClr  = vecs[i].clr;
            step();
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end
        idle_inputs();

        // SPI buffer load with no spiAck; a stray uartAck must not end the wait.
        ldReq   = 1'b1;
        ldSrc   = 3'd6;
        step();
        idle_inputs();
        uartAck = 1'b1;
        n_req   = 0;
        saw_bad = 1'b0;
        while (spiRdReq && n_req < 40) begin
            n_req++;
            if (accWrEn || uartRdReq || done || accMuxSel != 3'd6) saw_bad = 1'b1;
            step();
        end
        uartAck = 1'b0;
        check("tmo_req_cycles", 32'(n_req), 32'd16);
        check("tmo_wait_outputs", 32'(saw_bad), 32'd0);
        check("tmo_abort", 32'(outs()), 32'(pk(3'd7, 0, 0, 0, 0, 1, 1, 0)));
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        check("tmo_err_clr", 32'(outs()), 32'(pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));

        // UART ack arriving exactly on the terminal-count cycle.
        ldReq = 1'b1;
        ldSrc = 3'd4;
        step();
        idle_inputs();
        for (int i = 0; i < 15; i++) step();
        check("tc_still_waiting", 32'(outs()), 32'(pk(3'd4, 0, 1, 0, 1, 0, 0, 0)));
        uartAck = 1'b1;
        step();
        uartAck = 1'b0;
        check("tc_ack_wins", 32'(outs()), 32'(pk(3'd4, 1, 0, 0, 1, 1, 0, 0)));
        step();
        check("tc_back_idle", 32'(outs()), 32'(pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));

        // Set a sticky error, then reset in the middle of an SPI wait.
        ldReq = 1'b1;
        ldSrc = 3'd7;
        step();
        ldSrc = 3'd6;
        step();
        idle_inputs();
        check("rst_pre_wait", 32'(outs()), 32'(pk(3'd6, 0, 0, 1, 1, 0, 0, 1)));
        step();
        reset  = 1'b0;
        spiAck = 1'b1;
        step();
        check("rst_mid_load", 32'(outs()), 32'(pk(3'd7, 0, 0, 0, 0, 0, 0, 0)));
        reset   = 1'b1;
        saw_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            spiAck = 1'b0;
            if (accWrEn || done || busy || spiRdReq) saw_bad = 1'b1;
        end
        check("rst_no_late_write", 32'(saw_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
